tenthirty_game_ctrl: RTL and testbench
======================================

Name: tenthirty_game_ctrl

Overview:
- Game sequencer for the ten-and-a-half card game on the board.
- Converts debounced-rate button events (btn_m = hit/start, btn_r = stand) into a player/dealer turn sequence.
- Requests cards from the deck block over a req/ack handshake and accumulates hand totals in half-points.
- Decides the round result and drives totals and phase to the 7-segment display block.

Parameters:
- MAX_CARDS, 5: hand-size limit per side.
- DEALER_STAND, 14: dealer stops drawing at total ≥ this, in half-points (14 = 7.0).
- BUST_LIM, 21: highest legal total, in half-points (21 = 10.5).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-clk-wide pulse from the frequency divider; paces button sampling and dealer draws
- btn_m  in  1  hit / start (level)
- btn_r  in  1  stand (level)
- card_req  out  1  request next card from the deck
- card_ack  in  1  deck response; card_val valid in the same cycle
- card_val  in  4  card rank 1..13
- player_pts  out  6  player total, half-points
- dealer_pts  out  6  dealer total, half-points
- player_cnt  out  3  player cards held
- dealer_cnt  out  3  dealer cards held
- phase  out  3  0 IDLE, 1 P_DRAW, 2 P_DECIDE, 3 D_DRAW, 4 D_DECIDE, 5 COMPARE, 6 DONE
- result  out  2  00 none, 01 player win, 10 dealer win, 11 tie

Behaviour:
- Reset values: all outputs 0, phase = IDLE, button history registers 0.
- Reset asserted mid-round aborts the round; an outstanding card_req drops immediately.
- Button events:
  - btn_x registered on each tick; an event is a rising edge between consecutive tick samples, so one event per press.
  - Events are ignored outside IDLE, P_DECIDE and DONE.
  - If btn_m and btn_r events occur on the same tick in P_DECIDE, stand (btn_r) wins.
- Card value mapping:
  - Ranks 1..10 add 2×rank half-points.
  - Ranks 11..13 add 1.
  - Ranks 0 and 14..15 add 0 and still count as a card.
  - Totals saturate at 63.
- Handshake:
  - card_req is asserted on entry to P_DRAW/D_DRAW and held until card_ack = 1.
  - card_req deasserts the cycle after ack.
  - The total and count update on the clk edge that samples the ack, so they are visible in the next cycle.
  - card_ack with card_req low is ignored.
  - Ack is accepted in the first cycle of req (zero-wait deck allowed).
- State transitions:
  - IDLE: btn_m event → clear hands and result → P_DRAW.
  - P_DRAW: on ack → P_DECIDE.
  - P_DECIDE, checked in priority order:
    1. player_pts > BUST_LIM → result 10, DONE.
    2. player_cnt == MAX_CARDS → result 01, DONE (five-card win).
    3. player_pts == BUST_LIM → D_DRAW (automatic stand).
    4. btn_r event → D_DRAW.
    5. btn_m event → P_DRAW.
  - D_DRAW: entered only on tick; on ack → D_DECIDE.
  - D_DECIDE, checked in priority order:
    1. dealer_pts > BUST_LIM → result 01, DONE.
    2. dealer_pts ≥ DEALER_STAND or dealer_cnt == MAX_CARDS → COMPARE.
    3. Otherwise → D_DRAW at the next tick.
  - COMPARE: one cycle. Greater total wins; equal totals → result 11. Then DONE.
  - DONE: hands and result held; btn_m event → clear → P_DRAW (new round).
- Count widths: counts never exceed MAX_CARDS (cannot wrap).

Optional Feature:
- Macro: ROUND_SCORE_EN.
- Defined:
  - Adds outputs player_wins[7:0] and dealer_wins[7:0].
  - The matching counter increments by 1 on the cycle result becomes 01 or 10; ties increment neither.
  - Counters wrap 255 → 0.
  - Cleared only by rst_n.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with btn_m held high → all outputs 0, phase 0; first press after release required to start.
- Start, deck returns rank 13 then 10 (player_pts 1 → 21) → automatic stand, phase 3. Dealer gets 7 (14) → COMPARE → result 01.
- Player ranks 6 and 6 (24 > 21) → result 10, DONE; dealer_cnt stays 0.
- Player stands at 14 (rank 7); dealer gets 3 then 4 (6, 14) → COMPARE → tie, result 11. Dealer draws are separated by ≥1 tick.
- Player draws ranks 1,1,1,1,11 (9 half-points, 5 cards) → result 01 without dealer turn. Deck stalls ack for 7 cycles → card_req held for 7 cycles and totals unchanged until ack.
- btn_m and btn_r rising on the same tick in P_DECIDE → D_DRAW. With ROUND_SCORE_EN, two player wins → player_wins = 2; reset → 0.

Source files
------------

// File: rtl/tenthirty_game_ctrl.sv
// rtl/tenthirty_game_ctrl.sv - ten-and-a-half round sequencer; ROUND_SCORE_EN adds per-side win counters
module tenthirty_game_ctrl #(
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 14,
    parameter int BUST_LIM     = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_m,
    input  logic       btn_r,
    output logic       card_req,
    input  logic       card_ack,
    input  logic [3:0] card_val,
    output logic [5:0] player_pts,
    output logic [5:0] dealer_pts,
    output logic [2:0] player_cnt,
    output logic [2:0] dealer_cnt,
    output logic [2:0] phase,
    output logic [1:0] result
`ifdef ROUND_SCORE_EN
    ,
    output logic [7:0] player_wins,
    output logic [7:0] dealer_wins
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_P_DRAW   = 3'd1;
    localparam logic [2:0] S_P_DECIDE = 3'd2;
    localparam logic [2:0] S_D_DRAW   = 3'd3;
    localparam logic [2:0] S_D_DECIDE = 3'd4;
    localparam logic [2:0] S_COMPARE  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [2:0] CNT_MAX   = 3'(MAX_CARDS);
    localparam logic [5:0] STAND_PTS = 6'(DEALER_STAND);
    localparam logic [5:0] BUST_PTS  = 6'(BUST_LIM);

    logic [2:0] state;
    logic       btn_m_q, btn_r_q, primed;
    logic       ev_m, ev_r, ack_take;
    logic       p_bust, p_five, p_max, d_bust, d_stop;
    logic       set_pwin, set_dwin;

    function automatic logic [5:0] card_points(input logic [3:0] v);
        if (v >= 4'd1 && v <= 4'd10)
            return {1'b0, v, 1'b0};
        else if (v >= 4'd11 && v <= 4'd13)
            return 6'd1;
        else
            return 6'd0;
    endfunction

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

    // The first tick after reset only loads history, so a button held through
    // reset must be released and pressed again before it counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m_q <= 1'b0;
            btn_r_q <= 1'b0;
            primed  <= 1'b0;
        end else if (tick) begin
            btn_m_q <= btn_m;
            btn_r_q <= btn_r;
            primed  <= 1'b1;
        end
    end

    assign ev_m     = tick & primed & btn_m & ~btn_m_q;
    assign ev_r     = tick & primed & btn_r & ~btn_r_q;
    assign ack_take = card_req & card_ack;
    assign phase    = state;

    assign p_bust = player_pts > BUST_PTS;
    assign p_five = player_cnt == CNT_MAX;
    assign p_max  = player_pts == BUST_PTS;
    assign d_bust = dealer_pts > BUST_PTS;
    assign d_stop = (dealer_pts >= STAND_PTS) || (dealer_cnt == CNT_MAX);

    always_comb begin
        set_pwin = 1'b0;
        set_dwin = 1'b0;
        case (state)
            S_P_DECIDE: begin
                if (p_bust)
                    set_dwin = 1'b1;
                else if (p_five)
                    set_pwin = 1'b1;
            end
            S_D_DECIDE: begin
                if (d_bust)
                    set_pwin = 1'b1;
            end
            S_COMPARE: begin
                if (player_pts > dealer_pts)
                    set_pwin = 1'b1;
                else if (dealer_pts > player_pts)
                    set_dwin = 1'b1;
            end
            default: begin
                set_pwin = 1'b0;
                set_dwin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            card_req   <= 1'b0;
            player_pts <= 6'd0;
            dealer_pts <= 6'd0;
            player_cnt <= 3'd0;
            dealer_cnt <= 3'd0;
            result     <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (ev_m) begin
                        player_pts <= 6'd0;
                        dealer_pts <= 6'd0;
                        player_cnt <= 3'd0;
                        dealer_cnt <= 3'd0;
                        result     <= 2'b00;
                        card_req   <= 1'b1;
                        state      <= S_P_DRAW;
                    end
                end
                S_P_DRAW: begin
                    if (ack_take) begin
                        card_req   <= 1'b0;
                        player_pts <= sat_add(player_pts, card_points(card_val));
                        if (player_cnt < CNT_MAX)
                            player_cnt <= player_cnt + 3'd1;
                        state <= S_P_DECIDE;
                    end
                end
                S_P_DECIDE: begin
                    if (set_pwin || set_dwin) begin
                        result <= {set_dwin, set_pwin};
                        state  <= S_DONE;
                    end else if (p_max) begin
                        // Automatic stand still waits for a tick to pace the dealer.
                        if (tick) begin
                            card_req <= 1'b1;
                            state    <= S_D_DRAW;
                        end
                    end else if (ev_r) begin
                        card_req <= 1'b1;
                        state    <= S_D_DRAW;
                    end else if (ev_m) begin
                        card_req <= 1'b1;
                        state    <= S_P_DRAW;
                    end
                end
                S_D_DRAW: begin
                    if (ack_take) begin
                        card_req   <= 1'b0;
                        dealer_pts <= sat_add(dealer_pts, card_points(card_val));
                        if (dealer_cnt < CNT_MAX)
                            dealer_cnt <= dealer_cnt + 3'd1;
                        state <= S_D_DECIDE;
                    end
                end
                S_D_DECIDE: begin
                    if (set_pwin) begin
                        result <= 2'b01;
                        state  <= S_DONE;
                    end else if (d_stop) begin
                        state <= S_COMPARE;
                    end else if (tick) begin
                        card_req <= 1'b1;
                        state    <= S_D_DRAW;
                    end
                end
                S_COMPARE: begin
                    result <= (set_pwin || set_dwin) ? {set_dwin, set_pwin} : 2'b11;
                    state  <= S_DONE;
                end
                default: begin
                    card_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ROUND_SCORE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_wins <= 8'd0;
            dealer_wins <= 8'd0;
        end else begin
            if (set_pwin)
                player_wins <= player_wins + 8'd1;
            if (set_dwin)
                dealer_wins <= dealer_wins + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tenthirty_game_ctrl.sv
// tb/tb_tenthirty_game_ctrl.sv - scoreboard bench for tenthirty_game_ctrl with a stalling deck model
module tb_tenthirty_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, tick, btn_m, btn_r, card_ack;
    logic [3:0] card_val;
    logic       card_req;
    logic [5:0] player_pts, dealer_pts;
    logic [2:0] player_cnt, dealer_cnt, phase;
    logic [1:0] result;
`ifdef ROUND_SCORE_EN
    logic [7:0] player_wins, dealer_wins;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0] res;
        logic [5:0] pp;
        logic [5:0] dp;
        logic [2:0] pc;
        logic [2:0] dc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] deck_q[$];
    int         dealer_ack_ticks[$];
    int         stall_cycles = 0;
    int         last_wait = 0;
    int         stall_viol = 0;
    int         tick_count = 0;

    tenthirty_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .btn_m      (btn_m),
        .btn_r      (btn_r),
        .card_req   (card_req),
        .card_ack   (card_ack),
        .card_val   (card_val),
        .player_pts (player_pts),
        .dealer_pts (dealer_pts),
        .player_cnt (player_cnt),
        .dealer_cnt (dealer_cnt),
        .phase      (phase),
        .result     (result)
`ifdef ROUND_SCORE_EN
        ,
        .player_wins(player_wins),
        .dealer_wins(dealer_wins)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
            tick_count++;
        end
    end

    // Deck: answers card_req after stall_cycles waiting cycles, checking totals stay frozen meanwhile.
    initial begin
        bit         in_req;
        int         waited;
        logic [5:0] sp, sd;
        in_req   = 1'b0;
        waited   = 0;
        sp       = '0;
        sd       = '0;
        card_ack = 1'b0;
        card_val = 4'd0;
        forever begin
            @(negedge clk);
            card_ack = 1'b0;
            if (rst_n === 1'b1 && card_req === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    waited = 0;
                    sp     = player_pts;
                    sd     = dealer_pts;
                end
                if (waited < stall_cycles) begin
                    waited++;
                    if (player_pts !== sp || dealer_pts !== sd)
                        stall_viol++;
                end else begin
                    card_ack  = 1'b1;
                    card_val  = (deck_q.size() > 0) ? deck_q.pop_front() : 4'd0;
                    last_wait = waited;
                    in_req    = 1'b0;
                    if (phase == 3'd3)
                        dealer_ack_ticks.push_back(tick_count);
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic r);
        @(negedge clk);
        btn_m = m;
        btn_r = r;
        cyc(8);
        btn_m = 1'b0;
        btn_r = 1'b0;
        cyc(8);
        for (int i = 0; i < 60 && (phase == 3'd1 || phase == 3'd3); i++)
            @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (phase !== 3'd6 && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (phase !== 3'd6 || exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s_done phase=%0d want 6 (expected entries %0d)", name, phase, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        tests++;
        if (result !== e.res) begin
            fails++;
            $display("FAIL %s_result got %b want %b", name, result, e.res);
        end
        tests++;
        if (player_pts !== e.pp) begin
            fails++;
            $display("FAIL %s_player_pts got %0d want %0d", name, player_pts, e.pp);
        end
        tests++;
        if (dealer_pts !== e.dp) begin
            fails++;
            $display("FAIL %s_dealer_pts got %0d want %0d", name, dealer_pts, e.dp);
        end
        tests++;
        if (player_cnt !== e.pc) begin
            fails++;
            $display("FAIL %s_player_cnt got %0d want %0d", name, player_cnt, e.pc);
        end
        tests++;
        if (dealer_cnt !== e.dc) begin
            fails++;
            $display("FAIL %s_dealer_cnt got %0d want %0d", name, dealer_cnt, e.dc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn_m = 1'b1;
        btn_r = 1'b0;
        cyc(3);
        tests++;
        if ({card_req, player_pts, dealer_pts, player_cnt, dealer_cnt, phase, result} !== 24'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h want 0",
                     {card_req, player_pts, dealer_pts, player_cnt, dealer_cnt, phase, result});
        end
`ifdef ROUND_SCORE_EN
        tests++;
        if (player_wins !== 8'd0 || dealer_wins !== 8'd0) begin
            fails++;
            $display("FAIL reset_wins got %0d/%0d want 0/0", player_wins, dealer_wins);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc(16);
        tests++;
        if (phase !== 3'd0 || card_req !== 1'b0) begin
            fails++;
            $display("FAIL held_btn_start got phase=%0d req=%b want 0/0", phase, card_req);
        end
        btn_m = 1'b0;
        cyc(8);
    endtask

    task automatic test_auto_stand;
        int n0;
        n0 = dealer_ack_ticks.size();
        deck_q.push_back(4'd13);
        deck_q.push_back(4'd10);
        deck_q.push_back(4'd7);
        exp_q.push_back(exp_t'{2'b01, 6'd21, 6'd14, 3'd2, 3'd1});
        press(1'b1, 1'b0);
        tests++;
        if (player_pts !== 6'd1 || phase !== 3'd2) begin
            fails++;
            $display("FAIL first_card got pts=%0d phase=%0d want 1/2", player_pts, phase);
        end
        press(1'b1, 1'b0);
        wait_done("auto_stand");
        tests++;
        if (dealer_ack_ticks.size() != n0 + 1) begin
            fails++;
            $display("FAIL auto_stand_dealer_draws got %0d want 1", dealer_ack_ticks.size() - n0);
        end
    endtask

    task automatic test_bust;
        deck_q.push_back(4'd6);
        deck_q.push_back(4'd6);
        exp_q.push_back(exp_t'{2'b10, 6'd24, 6'd0, 3'd2, 3'd0});
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        wait_done("bust");
    endtask

    task automatic test_tie;
        int n0;
        n0 = dealer_ack_ticks.size();
        deck_q.push_back(4'd7);
        deck_q.push_back(4'd3);
        deck_q.push_back(4'd4);
        exp_q.push_back(exp_t'{2'b11, 6'd14, 6'd14, 3'd1, 3'd2});
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        wait_done("tie");
        tests++;
        if (dealer_ack_ticks.size() != n0 + 2) begin
            fails++;
            $display("FAIL tie_dealer_draws got %0d want 2", dealer_ack_ticks.size() - n0);
        end else if (dealer_ack_ticks[n0+1] - dealer_ack_ticks[n0] < 1) begin
            fails++;
            $display("FAIL tie_draw_spacing got %0d ticks want >=1",
                     dealer_ack_ticks[n0+1] - dealer_ack_ticks[n0]);
        end
    endtask

    task automatic test_five_card_stall;
        deck_q.push_back(4'd1);
        deck_q.push_back(4'd1);
        deck_q.push_back(4'd1);
        deck_q.push_back(4'd1);
        deck_q.push_back(4'd11);
        exp_q.push_back(exp_t'{2'b01, 6'd9, 6'd0, 3'd5, 3'd0});
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        stall_cycles = 7;
        press(1'b1, 1'b0);
        stall_cycles = 0;
        tests++;
        if (last_wait != 7 || stall_viol != 0) begin
            fails++;
            $display("FAIL stall got wait=%0d viol=%0d want 7/0", last_wait, stall_viol);
        end
        tests++;
        if (player_pts !== 6'd6 || player_cnt !== 3'd3) begin
            fails++;
            $display("FAIL stall_update got pts=%0d cnt=%0d want 6/3", player_pts, player_cnt);
        end
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        wait_done("five_card");
    endtask

    task automatic test_simultaneous;
        deck_q.push_back(4'd2);
        deck_q.push_back(4'd10);
        exp_q.push_back(exp_t'{2'b10, 6'd4, 6'd20, 3'd1, 3'd1});
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        wait_done("both_buttons");
`ifdef ROUND_SCORE_EN
        tests++;
        if (player_wins !== 8'd2 || dealer_wins !== 8'd2) begin
            fails++;
            $display("FAIL win_counters got %0d/%0d want 2/2", player_wins, dealer_wins);
        end
`endif
    endtask

    task automatic test_reset_abort;
        int n;
        deck_q.push_back(4'd5);
        stall_cycles = 20;
        @(negedge clk);
        btn_m = 1'b1;
        n = 0;
        while (card_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (card_req !== 1'b1) begin
            fails++;
            $display("FAIL abort_req_seen got %b want 1", card_req);
        end
        cyc(2);
        rst_n = 1'b0;
        #1;
        tests++;
        if (card_req !== 1'b0 || phase !== 3'd0 || player_pts !== 6'd0) begin
            fails++;
            $display("FAIL abort got req=%b phase=%0d pts=%0d want 0/0/0", card_req, phase, player_pts);
        end
`ifdef ROUND_SCORE_EN
        tests++;
        if (player_wins !== 8'd0 || dealer_wins !== 8'd0) begin
            fails++;
            $display("FAIL abort_wins got %0d/%0d want 0/0", player_wins, dealer_wins);
        end
`endif
        btn_m = 1'b0;
        stall_cycles = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
    endtask

    initial begin
        test_reset();
        test_auto_stand();
        test_bust();
        test_tie();
        test_five_card_stall();
        test_simultaneous();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
